// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: one outstanding imem request feeding a DEPTH-entry {pc, instr} FIFO.
// Define IFQ_BYPASS_EN to forward an ack straight to the consumer when the queue is empty.
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [63:0] startpc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [63:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  state_e        state_q;
  logic [63:0]   fetch_pc_q;
  logic [63:0]   imem_addr_q;
  logic          imem_req_q;

  logic queue_empty;
  logic ack_live;
  logic push_raw;
  logic bypass_valid;
  logic bypass_take;
  logic push;
  logic pop;

  // NOTE: every signal in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    queue_empty = (count_q == '0);
    ack_live    = imem_ack && ((state_q == REQ) || (state_q == WAIT));
    push_raw    = ack_live && !redirect;
`ifdef IFQ_BYPASS_EN
    bypass_valid = push_raw && queue_empty;
    bypass_take  = bypass_valid && inst_ready;
`else
    bypass_valid = 1'b0;
    bypass_take  = 1'b0;
`endif
    push = push_raw && !bypass_take;
    pop  = !queue_empty && inst_ready && !redirect;

    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_data};
    end
  end

  // The outstanding request address lives in imem_addr_q so FLUSH can retarget fetch_pc_q.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= startpc;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            fetch_pc_q  <= redirect_pc;
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= redirect_pc;
          end else if (count_q < FULL_CNT) begin
            state_q     <= REQ;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
          end
        end
        REQ, WAIT: begin
          if (imem_ack) begin
            if (redirect) begin
              fetch_pc_q  <= redirect_pc;
              state_q     <= REQ;
              imem_addr_q <= redirect_pc;
            end else begin
              fetch_pc_q <= fetch_pc_q + 64'd4;
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end
          end else if (redirect) begin
            fetch_pc_q <= redirect_pc;
            state_q    <= FLUSH;
          end else begin
            state_q <= WAIT;
          end
        end
        FLUSH: begin
          if (redirect) begin
            fetch_pc_q <= redirect_pc;
          end
          if (imem_ack) begin
            state_q     <= REQ;
            imem_addr_q <= redirect ? redirect_pc : fetch_pc_q;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = !queue_empty || bypass_valid;

  always_comb begin
    inst_out = '0;
    inst_pc  = '0;
    if (!queue_empty) begin
      inst_out = mem_q[rd_ptr_q].instr;
      inst_pc  = mem_q[rd_ptr_q].pc;
    end else if (bypass_valid) begin
      inst_out = imem_data;
      inst_pc  = fetch_pc_q;
    end
  end

  a_req_held: assert property (@(posedge CLK) disable iff (reset)
    imem_req && !imem_ack |=> imem_req && $stable(imem_addr));

  a_count_bound: assert property (@(posedge CLK) disable iff (reset)
    count_q <= FULL_CNT);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue (DEPTH=4): sequential fetch, full queue, redirects,
// address wrap, reset mid-request and the ack-cycle behaviour with and without IFQ_BYPASS_EN.
module tb_instr_fetch_queue;

  logic        CLK = 1'b0;
  logic        reset;
  logic [63:0] startpc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        inst_ready;

  int checks   = 0;
  int failures = 0;

  instr_fetch_queue #(.DEPTH(4)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .startpc    (startpc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("req_seen", 64'(imem_req), 64'd1);
  endtask

  // Memory model: ack arrives lat cycles after the request is first seen.
  task automatic serve(input int lat, input logic [31:0] data, output logic [63:0] addr);
    wait_req();
    addr = imem_addr;
    repeat (lat) @(negedge CLK);
    imem_ack  = 1'b1;
    imem_data = data;
    @(negedge CLK);
    imem_ack  = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] exp_pc;
    logic [31:0] word;
    logic        req_any;

    reset       = 1'b1;
    startpc     = 64'h1000;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_data   = '0;
    inst_ready  = 1'b1;
    repeat (2) @(negedge CLK);

    check("rst_req",   64'(imem_req),   64'd0);
    check("rst_addr",  imem_addr,       64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_out",   64'(inst_out),   64'd0);
    check("rst_pc",    inst_pc,         64'd0);
    reset = 1'b0;

    // Sequential fetch with latency 1 and an always-ready consumer.
    for (int i = 0; i < 3; i++) begin
      exp_pc = 64'h1000 + 64'(4 * i);
      word   = 32'hA000_0000 + 32'(i);
      serve(1, word, a);
      check("seq_addr",  a,               exp_pc);
      check("seq_valid", 64'(inst_valid), 64'd1);
      check("seq_pc",    inst_pc,         exp_pc);
      check("seq_out",   64'(inst_out),   64'(word));
    end

    // Fill the queue with the consumer stalled.
    @(negedge CLK);
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'h100C + 64'(4 * i);
      serve(1, 32'hB000_0000 + 32'(i), a);
      check("fill_addr", a, exp_pc);
    end
    check("full_count", 64'(dut.count_q), 64'd4);
    check("full_head",  inst_pc,          64'h100C);
    req_any = 1'b0;
    repeat (6) begin
      @(negedge CLK);
      req_any = req_any | imem_req;
    end
    check("full_no_req", 64'(req_any), 64'd0);
    inst_ready = 1'b1;
    @(negedge CLK);
    inst_ready = 1'b0;
    check("pop_head", inst_pc, 64'h1010);
    serve(1, 32'hB000_0004, a);
    check("refill_addr",  a,                64'h101C);
    check("refill_count", 64'(dut.count_q), 64'd4);

    // Redirect with a request outstanding; its data must be dropped.
    reset = 1'b1;
    @(negedge CLK);
    reset      = 1'b0;
    inst_ready = 1'b1;
    serve(1, 32'hC000_0000, a);
    serve(1, 32'hC000_0001, a);
    wait_req();
    check("rd_old_addr", imem_addr, 64'h1008);
    redirect    = 1'b1;
    redirect_pc = 64'h2000;
    @(negedge CLK);
    redirect = 1'b0;
    check("flush_req",   64'(imem_req),   64'd1);
    check("flush_addr",  imem_addr,       64'h1008);
    check("flush_valid", 64'(inst_valid), 64'd0);
    repeat (2) @(negedge CLK);
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    @(negedge CLK);
    imem_ack = 1'b0;
    check("drop_valid", 64'(inst_valid), 64'd0);
    check("drop_addr",  imem_addr,       64'h2000);
    serve(1, 32'h2222_0000, a);
    check("new_addr", a,             64'h2000);
    check("new_pc",   inst_pc,       64'h2000);
    check("new_out",  64'(inst_out), 64'h2222_0000);

    // Redirect in the same cycle as the ack.
    wait_req();
    check("co_addr0", imem_addr, 64'h2004);
    @(negedge CLK);
    imem_ack    = 1'b1;
    imem_data   = 32'h5555_5555;
    redirect    = 1'b1;
    redirect_pc = 64'h3000;
    @(negedge CLK);
    imem_ack = 1'b0;
    redirect = 1'b0;
    check("co_valid", 64'(inst_valid),   64'd0);
    check("co_count", 64'(dut.count_q),  64'd0);
    check("co_req",   64'(imem_req),     64'd1);
    check("co_addr",  imem_addr,         64'h3000);
    serve(1, 32'h3333_0000, a);
    check("co_pc", inst_pc, 64'h3000);

    // Fetch address wraps past the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge CLK);
    redirect = 1'b0;
    check("wrap_flush", 64'(inst_valid), 64'd0);
    serve(1, 32'h7777_0000, a);
    check("wrap_top", a,       64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc0", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    serve(1, 32'h7777_0001, a);
    check("wrap_zero", a,       64'h0);
    check("wrap_pc1",  inst_pc, 64'h0);

    // Reset in WAIT drops the request at once and ignores acks while held.
    wait_req();
    @(negedge CLK);
    startpc = 64'h5000;
    reset   = 1'b1;
    #1;
    check("arst_req",   64'(imem_req),   64'd0);
    check("arst_addr",  imem_addr,       64'd0);
    check("arst_valid", 64'(inst_valid), 64'd0);
    @(negedge CLK);
    imem_ack  = 1'b1;
    imem_data = 32'h9999_9999;
    @(negedge CLK);
    imem_ack = 1'b0;
    check("arst_ack_ign", 64'(inst_valid), 64'd0);
    reset = 1'b0;
    serve(1, 32'h5050_0000, a);
    check("post_rst_addr", a,       64'h5000);
    check("post_rst_pc",   inst_pc, 64'h5000);

    // Ack into an empty queue with a ready consumer.
    wait_req();
    check("byp_addr", imem_addr, 64'h5004);
    @(negedge CLK);
    imem_ack  = 1'b1;
    imem_data = 32'hB1B2_B3B4;
    #1;
`ifdef IFQ_BYPASS_EN
    check("byp_valid", 64'(inst_valid), 64'd1);
    check("byp_out",   64'(inst_out),   64'hB1B2_B3B4);
    check("byp_pc",    inst_pc,         64'h5004);
`else
    check("nobyp_valid", 64'(inst_valid), 64'd0);
`endif
    @(negedge CLK);
    imem_ack = 1'b0;
`ifdef IFQ_BYPASS_EN
    check("byp_not_pushed", 64'(inst_valid), 64'd0);
`else
    check("nobyp_valid1", 64'(inst_valid), 64'd1);
    check("nobyp_pc",     inst_pc,         64'h5004);
    check("nobyp_out",    64'(inst_out),   64'hB1B2_B3B4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    check("watchdog", 64'd0, 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
